// File: rtl/freq_meter_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : freq_meter_pkg
// Brief    : Shared types, gate encodings and field positions for freq_meter.
// Revision : 1.0 - initial release
// ============================================================================
package freq_meter_pkg;

    localparam logic [1:0] C_GATE_1S    = 2'd0;
    localparam logic [1:0] C_GATE_100MS = 2'd1;
    localparam logic [1:0] C_GATE_10MS  = 2'd2;
    localparam logic [1:0] C_GATE_1MS   = 2'd3;

    localparam logic [1:0] C_BYTE_0 = 2'd0;
    localparam logic [1:0] C_BYTE_1 = 2'd1;
    localparam logic [1:0] C_BYTE_2 = 2'd2;
    localparam logic [1:0] C_BYTE_3 = 2'd3;

    // Byte 3 layout: {overflow, gate_q[1:0], 3'b0, result[25:24]}
    localparam int C_B3_OVF_BIT  = 7;
    localparam int C_B3_GATE_LSB = 5;
    localparam int C_B3_RES_MSB  = 25;
    localparam int C_RES_EXT_W   = 26;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        MEASURE = 1'b1
    } state_t;

    function automatic int gate_len(input logic [1:0] sel, input int clk_hz);
        case (sel)
            C_GATE_1S:    return clk_hz;
            C_GATE_100MS: return clk_hz / 10;
            C_GATE_10MS:  return clk_hz / 100;
            default:      return clk_hz / 1000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/freq_meter_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : freq_meter_if
// Brief    : Measurement control inputs and result outputs of freq_meter.
// Revision : 1.0 - initial release
// ============================================================================
interface freq_meter_if #(
    parameter int CNT_W = 26
);
    logic             sig_in;
    logic             en;
    logic [1:0]       gate_sel;
    logic [1:0]       byte_sel;
    logic [CNT_W-1:0] result;
    logic [7:0]       result_byte;
    logic             valid;
    logic             busy;
    logic             overflow;

    modport master (
        output sig_in, en, gate_sel, byte_sel,
        input  result, result_byte, valid, busy, overflow
    );

    modport slave (
        input  sig_in, en, gate_sel, byte_sel,
        output result, result_byte, valid, busy, overflow
    );
endinterface
`default_nettype wire

// File: rtl/freq_meter_sync_edge_detect.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : sync_edge_detect
// Brief    : Multi-flop synchroniser followed by a rising-edge detector.
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign rise = r_sync[SYNC_STAGES-1] & ~r_prev;
endmodule
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : freq_meter
// Brief    : Gated rising-edge counter reporting sig_in frequency per window.
// Revision : 1.0 - initial release
// ============================================================================
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CLK_HZ      = 60_000_000,
    parameter int CNT_W       = 26,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    freq_meter_if.slave    bus
);
    localparam int               GATE_W    = $clog2(CLK_HZ);
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    state_t                  r_state;
    logic [1:0]              r_gate_q;
    logic [GATE_W-1:0]       r_gate_cnt;
    logic [CNT_W-1:0]        r_edge_cnt;
    logic [CNT_W-1:0]        r_result;
    logic                    r_ovf_acc;
    logic                    r_overflow;
    logic                    r_valid;

    logic                    w_rise;
    logic                    w_last;
    logic                    w_sat_hit;
    logic                    w_gate_chg;
    logic [GATE_W-1:0]       w_gate_end;
    logic [CNT_W-1:0]        w_cnt_next;
    logic [C_RES_EXT_W-1:0]  w_res_ext;
    logic [7:0]              w_byte;

    sync_edge_detect #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.sig_in),
        .rise  (w_rise)
    );

    assign w_gate_end = GATE_W'(gate_len(r_gate_q, CLK_HZ) - 1);
    assign w_last     = (r_gate_cnt == w_gate_end);
    assign w_sat_hit  = w_rise && (r_edge_cnt == C_CNT_MAX);
    assign w_cnt_next = (w_rise && !w_sat_hit) ? r_edge_cnt + CNT_W'(1) : r_edge_cnt;
    assign w_gate_chg = (bus.gate_sel != r_gate_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_gate_q   <= 2'd0;
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_result   <= '0;
            r_ovf_acc  <= 1'b0;
            r_overflow <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.en) begin
                        r_state  <= MEASURE;
                        r_gate_q <= bus.gate_sel;
                    end
                end
                MEASURE: begin
                    if (!bus.en && !w_last) begin
                        r_state    <= IDLE;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_ovf_acc  <= 1'b0;
                    end else if (w_last) begin
                        // Completion wins over a gate change; the new gate starts the next window
                        r_result   <= w_cnt_next;
                        r_overflow <= r_ovf_acc | w_sat_hit;
                        r_valid    <= 1'b1;
                        r_gate_q   <= bus.gate_sel;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_ovf_acc  <= 1'b0;
                        if (!bus.en) begin
                            r_state <= IDLE;
                        end
                    end else if (w_gate_chg) begin
                        r_gate_q   <= bus.gate_sel;
                        r_gate_cnt <= '0;
                        r_edge_cnt <= '0;
                        r_ovf_acc  <= 1'b0;
                    end else begin
                        r_gate_cnt <= r_gate_cnt + GATE_W'(1);
                        r_edge_cnt <= w_cnt_next;
                        r_ovf_acc  <= r_ovf_acc | w_sat_hit;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_res_ext = C_RES_EXT_W'(r_result);

    always_comb begin
        w_byte = '0;
        case (bus.byte_sel)
            C_BYTE_0: w_byte = w_res_ext[7:0];
            C_BYTE_1: w_byte = w_res_ext[15:8];
            C_BYTE_2: w_byte = w_res_ext[23:16];
            C_BYTE_3: begin
                w_byte[C_B3_OVF_BIT]       = r_overflow;
                w_byte[C_B3_GATE_LSB +: 2] = r_gate_q;
                w_byte[1:0]                = w_res_ext[C_B3_RES_MSB -: 2];
            end
            default: w_byte = '0;
        endcase
    end

    assign bus.result      = r_result;
    assign bus.result_byte = w_byte;
    assign bus.valid       = r_valid;
    assign bus.busy        = (r_state == MEASURE);
    assign bus.overflow    = r_overflow;
endmodule
`default_nettype wire
